// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types, round constants and FSM encoding for the ASCON permutation engine
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam logic P12 = 1'b0;
    localparam logic P6  = 1'b1;

    localparam logic [3:0] ROUND_END = 4'd12;

    // Entry i is the constant for round i; entry 0 sits in the low byte.
    localparam logic [11:0][7:0] ROUND_CONST = {
        8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96,
        8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } type_fsm;

    function automatic logic [3:0] start_index(input logic mode);
        return (mode == P6) ? 4'd6 : 4'd0;
    endfunction

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (idx == 4'(i)) c = ROUND_CONST[i];
        end
        return c;
    endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// rtl/ascon_perm_engine_if.sv - start/done handshake and state bus of the permutation engine
interface ascon_perm_engine_if;
    import ascon_pack::*;

    logic      start_i;
    logic      mode_i;
    type_state state_i;
    logic      busy_o;
    logic      done_o;
    type_state state_o;

    modport master (
        output start_i, mode_i, state_i,
        input  busy_o, done_o, state_o
    );

    modport slave (
        input  start_i, mode_i, state_i,
        output busy_o, done_o, state_o
    );

endinterface

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational ASCON round: constant addition, S-box layer, linear layer
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    type_state a;
    type_state s;

    always_comb begin
        a = state_i;
        a[2][7:0] = a[2][7:0] ^ round_const(round_i);

        // Bitsliced 5-bit S-box applied to all 64 columns at once.
        a[0] = a[0] ^ a[4];
        a[4] = a[4] ^ a[3];
        a[2] = a[2] ^ a[1];
        s[0] = a[0] ^ (~a[1] & a[2]);
        s[1] = a[1] ^ (~a[2] & a[3]);
        s[2] = a[2] ^ (~a[3] & a[4]);
        s[3] = a[3] ^ (~a[4] & a[0]);
        s[4] = a[4] ^ (~a[0] & a[1]);
        s[1] = s[1] ^ s[0];
        s[0] = s[0] ^ s[4];
        s[3] = s[3] ^ s[2];
        s[2] = ~s[2];

        state_o[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
        state_o[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
        state_o[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
        state_o[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
        state_o[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - iterative ASCON p^a / p^b engine computing UNROLL rounds per clock
module ascon_perm_engine
    import ascon_pack::*;
#(
    parameter int UNROLL = 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    ascon_perm_engine_if.slave bus
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
            $error("ascon_perm_engine: UNROLL must be 1, 2, 3 or 6");
        end
    endgenerate

    localparam logic [3:0] STEP = 4'(UNROLL);

    type_fsm    fsm_q, fsm_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] base_idx;
    type_state  state_q, state_d;
    type_state  chain [UNROLL+1];
    logic       accept;

    assign accept = (fsm_q != ST_RUN) && bus.start_i;

    // Outside RUN the chain is fed straight from the bus so the start edge does real work.
    assign base_idx = (fsm_q == ST_RUN) ? idx_q : start_index(bus.mode_i);
    assign chain[0] = (fsm_q == ST_RUN) ? state_q : bus.state_i;

    generate
        for (genvar k = 0; k < UNROLL; k++) begin : g_round
            ascon_round u_round (
                .state_i (chain[k]),
                .round_i (base_idx + 4'(k)),
                .state_o (chain[k+1])
            );
        end
    endgenerate

    always_comb begin
        fsm_d   = fsm_q;
        idx_d   = idx_q;
        state_d = state_q;
        if (fsm_q == ST_RUN || accept) begin
            state_d = chain[UNROLL];
            idx_d   = base_idx + STEP;
            fsm_d   = (base_idx + STEP == ROUND_END) ? ST_DONE : ST_RUN;
        end else if (fsm_q == ST_DONE) begin
            fsm_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= ST_IDLE;
            idx_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign bus.busy_o  = (fsm_q == ST_RUN);
    assign bus.done_o  = (fsm_q == ST_DONE);
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb/tb_ascon_perm_engine.sv - directed bench for ascon_perm_engine at UNROLL 1, 2, 3 and 6
module tb_ascon_perm_engine;
    import ascon_pack::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_perm_engine_if bus0();
    ascon_perm_engine_if bus1();
    ascon_perm_engine_if bus2();
    ascon_perm_engine_if bus3();

    ascon_perm_engine #(.UNROLL(1)) dut_u1 (.clock_i(clk), .reset_i(rst), .bus(bus0));
    ascon_perm_engine #(.UNROLL(2)) dut_u2 (.clock_i(clk), .reset_i(rst), .bus(bus1));
    ascon_perm_engine #(.UNROLL(3)) dut_u3 (.clock_i(clk), .reset_i(rst), .bus(bus2));
    ascon_perm_engine #(.UNROLL(6)) dut_u6 (.clock_i(clk), .reset_i(rst), .bus(bus3));

    logic      start  [4];
    logic      mode   [4];
    type_state st_in  [4];
    logic      busy   [4];
    logic      done   [4];
    type_state st_out [4];

    assign bus0.start_i = start[0]; assign bus0.mode_i = mode[0]; assign bus0.state_i = st_in[0];
    assign bus1.start_i = start[1]; assign bus1.mode_i = mode[1]; assign bus1.state_i = st_in[1];
    assign bus2.start_i = start[2]; assign bus2.mode_i = mode[2]; assign bus2.state_i = st_in[2];
    assign bus3.start_i = start[3]; assign bus3.mode_i = mode[3]; assign bus3.state_i = st_in[3];
    assign busy[0] = bus0.busy_o; assign done[0] = bus0.done_o; assign st_out[0] = bus0.state_o;
    assign busy[1] = bus1.busy_o; assign done[1] = bus1.done_o; assign st_out[1] = bus1.state_o;
    assign busy[2] = bus2.busy_o; assign done[2] = bus2.done_o; assign st_out[2] = bus2.state_o;
    assign busy[3] = bus3.busy_o; assign done[3] = bus3.done_o; assign st_out[3] = bus3.state_o;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Table form of the S-box; index bit 4 is x0, bit 0 is x4.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic type_state ref_perm(input type_state s_in, input int first);
        type_state  s;
        logic [4:0] sb;
        s = s_in;
        for (int r = first; r < 12; r++) begin
            s[2][7:0] = s[2][7:0] ^ 8'(240 - 15 * r);
            for (int j = 0; j < 64; j++) begin
                sb = SBOX[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
                {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]} = sb;
            end
            s[0] = s[0] ^ rot(s[0], 19) ^ rot(s[0], 28);
            s[1] = s[1] ^ rot(s[1], 61) ^ rot(s[1], 39);
            s[2] = s[2] ^ rot(s[2], 1)  ^ rot(s[2], 6);
            s[3] = s[3] ^ rot(s[3], 10) ^ rot(s[3], 17);
            s[4] = s[4] ^ rot(s[4], 7)  ^ rot(s[4], 41);
        end
        return s;
    endfunction

    function automatic type_state mk(input logic [63:0] x0, x1, x2, x3, x4);
        type_state s;
        s[0] = x0; s[1] = x1; s[2] = x2; s[3] = x3; s[4] = x4;
        return s;
    endfunction

    function automatic type_state rnd_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic pulse_start(input int u, input logic m, input type_state v);
        @(negedge clk);
        start[u] = 1'b1;
        mode[u]  = m;
        st_in[u] = v;
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    // Observes 20 cycles starting at the negedge after the start edge.
    task automatic wait_done(input int u, output int lat, output int busy_cnt, output int pulses);
        lat = -1; busy_cnt = 0; pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (busy[u]) busy_cnt++;
            if (done[u]) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    type_state va, vb, vc, vd, v;
    type_state exp_q [$];
    int        lat, bcnt, pcnt, last_done, n_done;
    int        pb_lat [4] = '{5, 2, 1, 0};

    initial begin
        va = mk(64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff,
                64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a);
        vb = mk(64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0000000000000000,
                64'hffffffffffffffff, 64'h5555aaaa3333cccc);
        vc = mk(64'h1, 64'h2, 64'h4, 64'h8, 64'h10);
        vd = mk(64'hdeadbeefdeadbeef, 64'hcafef00dcafef00d, 64'h0, 64'h1, 64'h2);

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b1; mode[i] = P6; st_in[i] = va;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_state", st_out[0], 0);
        check("rst_start_ignored_u6", done[3], 0);
        check("rst_state_u6", st_out[3], 0);
        for (int i = 0; i < 4; i++) start[i] = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy[0], 0);
        check("idle_done", done[0], 0);
        check("idle_state", st_out[0], 0);

        pulse_start(0, P12, va);
        wait_done(0, lat, bcnt, pcnt);
        check("pa_u1_latency", lat, 11);
        check("pa_u1_pulses", pcnt, 1);
        check("pa_u1_busy_cycles", bcnt, 11);
        check("pa_u1_state", st_out[0], ref_perm(va, 0));

        for (int u = 0; u < 4; u++) begin
            pulse_start(u, P6, va);
            wait_done(u, lat, bcnt, pcnt);
            check($sformatf("pb_u%0d_latency", u), lat, pb_lat[u]);
            check($sformatf("pb_u%0d_busy", u), bcnt, pb_lat[u]);
            check($sformatf("pb_u%0d_pulses", u), pcnt, 1);
            check($sformatf("pb_u%0d_state", u), st_out[u], ref_perm(va, 6));
        end

        // Start held high on the UNROLL=3 engine; state_i changes every cycle.
        @(negedge clk);
        start[2] = 1'b1; mode[2] = P12; st_in[2] = vb;
        exp_q.push_back(ref_perm(vb, 0));
        last_done = 0; n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done[2]) begin
                n_done++;
                check("b2b_period", c - last_done, 4);
                check("b2b_state", st_out[2], exp_q.pop_front());
                last_done = c;
                v = rnd_state();
                st_in[2] = v;
                exp_q.push_back(ref_perm(v, 0));
            end else begin
                st_in[2] = rnd_state();
            end
        end
        start[2] = 1'b0;
        check("b2b_done_count", n_done, 3);

        pulse_start(0, P12, vc);
        repeat (3) @(negedge clk);
        start[0] = 1'b1; mode[0] = P6; st_in[0] = vd;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, lat, bcnt, pcnt);
        check("run_start_latency", lat, 7);
        check("run_start_pulses", pcnt, 1);
        check("run_start_state", st_out[0], ref_perm(vc, 0));

        pulse_start(0, P12, va);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        check("abort_state", st_out[0], 0);
        wait_done(0, lat, bcnt, pcnt);
        check("abort_no_done", pcnt, 0);
        pulse_start(0, P12, vb);
        wait_done(0, lat, bcnt, pcnt);
        check("after_abort_latency", lat, 11);
        check("after_abort_state", st_out[0], ref_perm(vb, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ascon_perm_engine.md
# ascon_perm_engine

Iterative, parametrised ASCON permutation core. Runs either the 12-round initialisation/finalisation permutation (p^a) or the 6-round data-processing permutation (p^b) on a 320-bit state, with a configurable number of rounds per clock. It replaces standalone per-layer instances (constant addition, substitution, diffusion) with one sequenced engine. The ASCON-128 mode FSM drives it through a start/done handshake.

## Interface

Parameters:
- UNROLL, default 1: rounds computed per clock. Legal values are 1, 2, 3 and 6, which divide both 6 and 12. Any other value is an elaboration error.

Ports:
- clock_i, in, 1: single clock, rising edge.
- reset_i, in, 1: reset, synchronous, active-high.
- start_i, in, 1: request a permutation. Sampled only in IDLE or DONE.
- mode_i, in, 1: 0 selects p^a (12 rounds); 1 selects p^b (6 rounds). Sampled with start_i.
- state_i, in, type_state (5×64): input state. Sampled with start_i.
- busy_o, out, 1: high while in RUN.
- done_o, out, 1: one-cycle pulse; state_o is valid.
- state_o, out, type_state: result register. Holds its value until the next accepted start.

## Operation

- Round i (0..11) uses constant c_i = 0xF0 − 15·i, giving F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B. c_i is XORed into the low byte of x2, then the S-box layer runs, then the linear layer.
- p^a covers rounds 0..11. p^b covers rounds 6..11, i.e. constants 96..4B.
- N = R / UNROLL cycles, where R = 12 or 6. Examples: UNROLL=1 gives 12/6; UNROLL=3 gives 4/2; UNROLL=6 gives 2/1.
- FSM states:
  - IDLE: on start_i, load state_i through the round datapath at round index 0 (p^a) or 6 (p^b). The start edge itself computes the first UNROLL rounds. Go to RUN, or to DONE if N=1.
  - RUN: each edge applies UNROLL rounds to the state register and advances the index by UNROLL. When the index reaches 12 after the edge, go to DONE. start_i is ignored.
  - DONE: done_o=1 for this single cycle. If start_i is high, it is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Round index: 4-bit counter. Its terminal value is 12; it never wraps past 12.
- reset_i has priority over everything. It aborts RUN mid-operation: no done_o pulse, state discarded.

## Timing

- Reset values: FSM=IDLE, index=0, state register and state_o = 0, busy_o=0, done_o=0.
- start_i sampled high at edge t:
  - The state after UNROLL rounds is registered at edge t.
  - busy_o is high from edge t until edge t+N−1.
  - The result is registered at edge t+N−1.
  - done_o is high during the cycle following edge t+N−1.
- Latency from start edge to done_o rising = N−1 edges. For p^a at UNROLL=1, done_o is high after edge t+11.
- Back-to-back: a start asserted during the DONE cycle begins a new permutation on that edge, with no idle bubble.
- state_o is a direct copy of the state register and changes only on edges where the FSM computes.
- Critical path: UNROLL chained rounds plus the input mux.

## Structure

- The ascon_pack package holds:
  - type_state
  - the 12-entry round-constant array
  - mode constants (P12=0, P6=1)
  - the FSM state enum
  - the start index function for each mode
- Sub-module ascon_round: purely combinational. Inputs are state and 4-bit round index; output is state after constant, S-box and linear layer. It is instantiated UNROLL times in a generate chain, with indices idx, idx+1, and so on.
- The engine itself contains only the FSM, the counter, the input mux and the state register.

## Test plan

- Reset, then hold IDLE: busy_o=0, done_o=0, state_o=0. Asserting start_i in the same cycle as reset_i is ignored.
- p^a on {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaaff, 4ed0ec0b98c529b7, c8cddf37bcd0284a}, UNROLL=1:
  - done_o pulses exactly once, 11 edges after the start edge.
  - state_o equals the ASCON C reference p^12 output.
  - busy_o is high for 11 cycles.
- p^b on the same state at UNROLL=1, 2, 3 and 6:
  - done_o arrives after 5, 2, 1 and 0 edges respectively.
  - All four state_o values are identical and equal the reference p^6.
- start_i held high continuously, UNROLL=3, mode_i=0: done_o pulses every 4 cycles, and each result matches p^12 of the state_i presented at its start.
- start_i pulsed during RUN with a different state_i: it is ignored, and the result is unchanged from the uninterrupted run.
- reset_i asserted at the 5th RUN edge: the next cycle is IDLE, with state_o=0 and no done_o. A subsequent start completes normally.
